// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: presents pc to the direct-mapped I-cache, refills misses byte-wise
// from the memory controller, and hands instructions to decode. FETCH_PERF_CNT_EN enables hit/miss counters.
module if_fetch_unit #(
  parameter int                ADDR_W   = 32,
  parameter int                INST_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  output logic [ADDR_W-1:0] cache_addr,
  input  logic [INST_W-1:0] cache_data,
  input  logic              cache_hit,
  output logic              cache_replace,
  output logic [INST_W-1:0] cache_wdata,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [7:0]        mem_rdata,
  input  logic              jump_en,
  input  logic [ADDR_W-1:0] jump_addr,
  input  logic              id_stall,
  output logic              inst_valid,
  output logic [INST_W-1:0] inst,
  output logic [ADDR_W-1:0] inst_pc,
  output logic [31:0]       hit_cnt,
  output logic [31:0]       miss_cnt,
  output logic [1:0]        dbg_state
);

  typedef enum logic [1:0] {
    ST_LOOKUP = 2'd0,
    ST_REFILL = 2'd1,
    ST_WRITE  = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [1:0]        cnt_q, cnt_d;
  logic [INST_W-1:0] buf_q, buf_d;
  logic [INST_W-1:0] inst_q, inst_d;
  logic [ADDR_W-1:0] inst_pc_q, inst_pc_d;
  logic              inst_valid_q, inst_valid_d;
  logic              slot_free;

  // Decode handshake: inst/inst_pc are offered while inst_valid=1 and consumed on any edge
  // where id_stall=0; while inst_valid=1 and id_stall=1 the slot holds unchanged.
  assign slot_free  = !inst_valid_q || !id_stall;

  assign cache_addr  = pc_q;
  assign cache_wdata = buf_q;
  assign mem_addr    = pc_q + ADDR_W'(cnt_q);
  assign inst_valid  = inst_valid_q;
  assign inst        = inst_q;
  assign inst_pc     = inst_pc_q;
  assign dbg_state   = state_q;

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    cnt_d         = cnt_q;
    buf_d         = buf_q;
    inst_d        = inst_q;
    inst_pc_d     = inst_pc_q;
    inst_valid_d  = inst_valid_q;
    mem_req       = 1'b0;
    cache_replace = 1'b0;
    if (slot_free) inst_valid_d = 1'b0;

    case (state_q)
      ST_LOOKUP: begin
        if (cache_hit) begin
          if (slot_free) begin
            inst_d       = cache_data;
            inst_pc_d    = pc_q;
            inst_valid_d = 1'b1;
            pc_d         = pc_q + ADDR_W'(4);
          end
        end else begin
          state_d = ST_REFILL;
          cnt_d   = 2'd0;
        end
      end
      ST_REFILL: begin
        mem_req = 1'b1;
        if (mem_ack) begin
          buf_d[{cnt_q, 3'b000} +: 8] = mem_rdata;
          cnt_d = cnt_q + 2'd1;
          if (cnt_q == 2'd3) state_d = ST_WRITE;
        end
      end
      ST_WRITE: begin
        cache_replace = 1'b1;
        state_d       = ST_LOOKUP;
      end
      default: state_d = ST_LOOKUP;
    endcase

    // A redirect abandons any refill in flight; its partial word is never written.
    if (jump_en) begin
      pc_d          = {jump_addr[ADDR_W-1:2], 2'b00};
      inst_valid_d  = 1'b0;
      state_d       = ST_LOOKUP;
      cnt_d         = 2'd0;
      buf_d         = buf_q;
      cache_replace = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_LOOKUP;
      pc_q         <= RESET_PC;
      cnt_q        <= 2'd0;
      buf_q        <= '0;
      inst_q       <= '0;
      inst_pc_q    <= '0;
      inst_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      cnt_q        <= cnt_d;
      buf_q        <= buf_d;
      inst_q       <= inst_d;
      inst_pc_q    <= inst_pc_d;
      inst_valid_q <= inst_valid_d;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] hit_cnt_q, hit_cnt_d, miss_cnt_q, miss_cnt_d;

  always_comb begin
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    if (state_q == ST_LOOKUP && cache_hit && slot_free) hit_cnt_d = hit_cnt_q + 32'd1;
    if (state_q == ST_LOOKUP && !cache_hit && !jump_en) miss_cnt_d = miss_cnt_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  assign hit_cnt  = hit_cnt_q;
  assign miss_cnt = miss_cnt_q;
`else
  assign hit_cnt  = '0;
  assign miss_cnt = '0;
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit with a behavioural direct-mapped cache and byte memory.
module tb_if_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] cache_addr, cache_data, cache_wdata;
  logic        cache_hit, cache_replace;
  logic        mem_req, mem_ack;
  logic [31:0] mem_addr;
  logic [7:0]  mem_rdata;
  logic        jump_en;
  logic [31:0] jump_addr;
  logic        id_stall;
  logic        inst_valid;
  logic [31:0] inst, inst_pc;
  logic [31:0] hit_cnt, miss_cnt;
  logic [1:0]  dbg_state;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  if_fetch_unit #(.ADDR_W(32), .INST_W(32), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst(rst),
    .cache_addr(cache_addr), .cache_data(cache_data), .cache_hit(cache_hit),
    .cache_replace(cache_replace), .cache_wdata(cache_wdata),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .jump_en(jump_en), .jump_addr(jump_addr), .id_stall(id_stall),
    .inst_valid(inst_valid), .inst(inst), .inst_pc(inst_pc),
    .hit_cnt(hit_cnt), .miss_cnt(miss_cnt), .dbg_state(dbg_state)
  );

  // Behavioural 64-entry direct-mapped cache, full address as tag.
  logic        cv [64];
  logic [31:0] ctag [64];
  logic [31:0] cdata [64];
  logic        flush = 1'b0;
  logic        pre_we = 1'b0;
  logic [31:0] pre_addr = '0, pre_data = '0;

  assign cache_hit  = cv[cache_addr[7:2]] && (ctag[cache_addr[7:2]] == cache_addr);
  assign cache_data = cdata[cache_addr[7:2]];

  always @(posedge clk) begin
    if (flush) for (int i = 0; i < 64; i++) cv[i] <= 1'b0;
    if (pre_we) begin
      cv[pre_addr[7:2]]    <= 1'b1;
      ctag[pre_addr[7:2]]  <= pre_addr;
      cdata[pre_addr[7:2]] <= pre_data;
    end else if (cache_replace) begin
      cv[cache_addr[7:2]]    <= 1'b1;
      ctag[cache_addr[7:2]]  <= cache_addr;
      cdata[cache_addr[7:2]] <= cache_wdata;
    end
  end

  // Byte memory: the first word holds 13,00,50,00; elsewhere byte = addr[7:0]^5A.
  function automatic logic [7:0] mem_byte(input logic [31:0] a);
    case (a)
      32'd0:   return 8'h13;
      32'd1:   return 8'h00;
      32'd2:   return 8'h50;
      32'd3:   return 8'h00;
      default: return a[7:0] ^ 8'h5a;
    endcase
  endfunction

  function automatic logic [31:0] exp_word(input logic [31:0] a);
    return {mem_byte(a + 3), mem_byte(a + 2), mem_byte(a + 1), mem_byte(a)};
  endfunction

  int wait_cnt = 0;
  int ack_delay = 0;
  assign mem_ack   = mem_req && (wait_cnt >= ack_delay);
  assign mem_rdata = mem_byte(mem_addr);

  always @(posedge clk) begin
    if (!mem_req || mem_ack) wait_cnt <= 0;
    else                     wait_cnt <= wait_cnt + 1;
  end

  task automatic test_reset();
    rst = 1'b1; flush = 1'b1; jump_en = 1'b0; jump_addr = '0; id_stall = 1'b0; ack_delay = 0;
    @(negedge clk); flush = 1'b0;
    @(negedge clk);
    checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL reset_inst_valid: got %b expected 0", inst_valid); end
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL reset_mem_req: got %b expected 0", mem_req); end
    checks++; if (cache_addr !== 32'h0) begin errors++; $display("FAIL reset_pc: got %h expected 00000000", cache_addr); end
    checks++; if (inst !== 32'h0 || inst_pc !== 32'h0) begin errors++; $display("FAIL reset_inst: got %h/%h expected 0/0", inst, inst_pc); end
    checks++; if (hit_cnt !== 32'h0 || miss_cnt !== 32'h0) begin errors++; $display("FAIL reset_cnt: got %0d/%0d expected 0/0", hit_cnt, miss_cnt); end
    checks++; if (dbg_state !== 2'd0) begin errors++; $display("FAIL reset_state: got %0d expected 0", dbg_state); end
    rst = 1'b0;
    for (int cyc = 1; cyc <= 7; cyc++) begin
      @(negedge clk);
      if (cyc <= 4) begin
        checks++; if (mem_req !== 1'b1 || mem_addr !== 32'(cyc - 1)) begin errors++; $display("FAIL miss_req_c%0d: got req=%b addr=%h expected req=1 addr=%h", cyc, mem_req, mem_addr, cyc - 1); end
        checks++; if (cache_replace !== 1'b0) begin errors++; $display("FAIL miss_norepl_c%0d: got %b expected 0", cyc, cache_replace); end
      end
      if (cyc == 5) begin
        checks++; if (cache_replace !== 1'b1 || cache_wdata !== 32'h00500013 || mem_req !== 1'b0) begin errors++; $display("FAIL miss_write: got repl=%b wdata=%h req=%b expected 1/00500013/0", cache_replace, cache_wdata, mem_req); end
      end
      if (cyc == 6) begin
        checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL miss_early_valid: got %b expected 0", inst_valid); end
      end
      if (cyc == 7) begin
        checks++; if (inst_valid !== 1'b1 || inst !== 32'h00500013 || inst_pc !== 32'h0) begin errors++; $display("FAIL miss_latency: got v=%b inst=%h pc=%h expected 1/00500013/0", inst_valid, inst, inst_pc); end
      end
    end
  endtask

  task automatic test_hit_stream();
    @(negedge clk); jump_en = 1'b1; jump_addr = 32'h0; flush = 1'b1;
    @(negedge clk); flush = 1'b0; pre_we = 1'b1; pre_addr = 32'h0; pre_data = 32'hc0de0000;
    @(negedge clk); pre_addr = 32'h4; pre_data = 32'hc0de0004;
    @(negedge clk); pre_addr = 32'h8; pre_data = 32'hc0de0008;
    @(negedge clk); pre_we = 1'b0; jump_en = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      checks++; if (inst_valid !== 1'b1 || inst_pc !== 32'(4 * (k - 1)) || inst !== (32'hc0de0000 | 32'(4 * (k - 1)))) begin errors++; $display("FAIL hit_stream_k%0d: got v=%b pc=%h inst=%h expected 1/%h", k, inst_valid, inst_pc, inst, 4 * (k - 1)); end
      checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL hit_noreq_k%0d: got %b expected 0", k, mem_req); end
    end
    @(negedge clk);
    checks++; if (mem_req !== 1'b1 || mem_addr !== 32'hc) begin errors++; $display("FAIL hit_stream_miss: got req=%b addr=%h expected 1/0000000c", mem_req, mem_addr); end
  endtask

  task automatic test_stall();
    @(negedge clk); jump_en = 1'b1; jump_addr = 32'h0;
    @(negedge clk); jump_en = 1'b0;
    @(negedge clk); id_stall = 1'b1;
    for (int k = 2; k <= 4; k++) begin
      @(negedge clk);
      checks++; if (inst_valid !== 1'b1 || inst_pc !== 32'h0 || inst !== 32'hc0de0000 || cache_addr !== 32'h4) begin errors++; $display("FAIL stall_hold_k%0d: got v=%b pc=%h inst=%h nextpc=%h expected 1/0/c0de0000/4", k, inst_valid, inst_pc, inst, cache_addr); end
    end
    id_stall = 1'b0;
    @(negedge clk);
    checks++; if (inst_valid !== 1'b1 || inst_pc !== 32'h4) begin errors++; $display("FAIL stall_release: got v=%b pc=%h expected 1/4", inst_valid, inst_pc); end
  endtask

  task automatic test_jump_abort();
    int n;
    @(negedge clk); jump_en = 1'b1; jump_addr = 32'h40; flush = 1'b1;
    @(negedge clk); jump_en = 1'b0; flush = 1'b0;
    @(negedge clk); @(negedge clk); @(negedge clk);
    checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h42) begin errors++; $display("FAIL jump_pre_addr: got req=%b addr=%h expected 1/42", mem_req, mem_addr); end
    jump_en = 1'b1; jump_addr = 32'h1003;
    @(negedge clk); jump_en = 1'b0;
    checks++; if (cache_replace !== 1'b0 || mem_req !== 1'b0 || inst_valid !== 1'b0) begin errors++; $display("FAIL jump_abort: got repl=%b req=%b v=%b expected 0/0/0", cache_replace, mem_req, inst_valid); end
    checks++; if (cache_addr !== 32'h1000 || dbg_state !== 2'd0) begin errors++; $display("FAIL jump_target: got pc=%h st=%0d expected 1000/0", cache_addr, dbg_state); end
    @(negedge clk);
    checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h1000) begin errors++; $display("FAIL jump_refill: got req=%b addr=%h expected 1/1000", mem_req, mem_addr); end
    n = 0;
    while (!inst_valid && n < 20) begin @(negedge clk); n++; end
    checks++; if (inst_valid !== 1'b1 || inst_pc !== 32'h1000 || inst !== exp_word(32'h1000)) begin errors++; $display("FAIL jump_result: got v=%b pc=%h inst=%h expected 1/1000/%h", inst_valid, inst_pc, inst, exp_word(32'h1000)); end
  endtask

  task automatic test_slow_ack();
    int n;
    ack_delay = 5;
    @(negedge clk); jump_en = 1'b1; jump_addr = 32'h80; flush = 1'b1;
    @(negedge clk); jump_en = 1'b0; flush = 1'b0;
    for (int i = 0; i < 4; i++) begin
      n = 0;
      do begin
        @(negedge clk); n++;
        checks++; if (mem_req !== 1'b1 || mem_addr !== 32'(32'h80 + i)) begin errors++; $display("FAIL slow_hold_b%0d: got req=%b addr=%h expected 1/%h", i, mem_req, mem_addr, 32'h80 + i); end
      end while (!mem_ack && n < 20);
      checks++; if (n != 6) begin errors++; $display("FAIL slow_wait_b%0d: got %0d cycles expected 6", i, n); end
    end
    n = 0;
    while (!inst_valid && n < 10) begin @(negedge clk); n++; end
    checks++; if (inst_valid !== 1'b1 || inst_pc !== 32'h80 || inst !== exp_word(32'h80)) begin errors++; $display("FAIL slow_word: got v=%b pc=%h inst=%h expected 1/80/%h", inst_valid, inst_pc, inst, exp_word(32'h80)); end
    ack_delay = 0;
  endtask

  task automatic test_reset_mid_refill();
    @(negedge clk); jump_en = 1'b1; jump_addr = 32'h40; flush = 1'b1;
    @(negedge clk); jump_en = 1'b0; flush = 1'b0;
    @(negedge clk); @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    checks++; if (cache_addr !== 32'h0 || mem_req !== 1'b0 || cache_replace !== 1'b0 || inst_valid !== 1'b0 || dbg_state !== 2'd0) begin errors++; $display("FAIL rst_mid_refill: got pc=%h req=%b repl=%b v=%b st=%0d expected 0/0/0/0/0", cache_addr, mem_req, cache_replace, inst_valid, dbg_state); end
  endtask

  task automatic test_perf();
    int n;
    logic [31:0] exp_hit, exp_miss;
`ifdef FETCH_PERF_CNT_EN
    exp_hit = 32'd4; exp_miss = 32'd1;
`else
    exp_hit = 32'd0; exp_miss = 32'd0;
`endif
    @(negedge clk); rst = 1'b1; flush = 1'b1;
    @(negedge clk); flush = 1'b0; pre_we = 1'b1; pre_addr = 32'h4; pre_data = 32'hbeef0004;
    @(negedge clk); pre_addr = 32'h8; pre_data = 32'hbeef0008;
    @(negedge clk); pre_addr = 32'hc; pre_data = 32'hbeef000c;
    @(negedge clk); pre_we = 1'b0; rst = 1'b0;
    n = 0;
    while (!(inst_valid && inst_pc == 32'hc) && n < 30) begin @(negedge clk); n++; end
    checks++; if (inst_valid !== 1'b1 || inst_pc !== 32'hc || inst !== 32'hbeef000c || n != 10) begin errors++; $display("FAIL perf_seq: got v=%b pc=%h inst=%h after %0d cycles expected 1/c/beef000c/10", inst_valid, inst_pc, inst, n); end
    checks++; if (hit_cnt !== exp_hit) begin errors++; $display("FAIL perf_hit_cnt: got %0d expected %0d", hit_cnt, exp_hit); end
    checks++; if (miss_cnt !== exp_miss) begin errors++; $display("FAIL perf_miss_cnt: got %0d expected %0d", miss_cnt, exp_miss); end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_hit_stream();
    test_stall();
    test_jump_abort();
    test_slow_ack();
    test_reset_mid_refill();
    test_perf();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
